mdc_transpose: RTL and testbench
================================

MDC_TRANSPOSE -- requirements
Module: mdc_transpose

Interface
REQ-001 Parameter LANES, default 4, number of parallel complex lanes; legal values 2, 4, 8.
REQ-002 Parameter DW, default 64, complex word width; real part in [DW-1:DW/2], imaginary part in [DW/2-1:0].
REQ-003 The block SHALL use one clock and a synchronous, active-high reset: CLK input 1, rising-edge clock; RST input 1, synchronous active-high reset.
REQ-004 IN_VALID input 1, input beat qualifier.
REQ-005 BYPASS input 1, pass-through mode request.
REQ-006 D input LANES*DW, input beat; lane i occupies D[i*DW +: DW].
REQ-007 OUT_VALID output 1, output beat qualifier.
REQ-008 OUT_FIRST output 1, high on beat 0 of an output block.
REQ-009 OUT_LAST output 1, high on beat LANES-1 of an output block.
REQ-010 Q output LANES*DW, output beat; lane j occupies Q[j*DW +: DW].

Function
REQ-011 Block = LANES consecutive valid input beats; in transpose mode, output beat r lane j SHALL equal input beat j lane r.
REQ-012 Storage: two LANES x LANES x DW banks, ping-pong.
  - Write counter WCNT (log2 LANES bits) advances only on IN_VALID.
  - The bank toggles on the edge sampling beat LANES-1.
REQ-013 Gaps in IN_VALID SHALL stall WCNT without loss; a partial block is held indefinitely.
REQ-014 Read sequencer states: IDLE and READ.
  - IDLE->READ on block completion.
  - READ lasts exactly LANES cycles, RCNT 0..LANES-1, independent of IN_VALID.
  - READ->IDLE after RCNT=LANES-1, unless another block completed on that same edge, in which case READ restarts at RCNT=0 on the other bank.
REQ-015 Q, OUT_VALID, OUT_FIRST and OUT_LAST SHALL be registered.
  - Output beat r appears r+1 cycles after the edge that completes the block.
  - Contiguous input: first output beat is valid LANES+1 cycles after the first input beat is sampled.
REQ-016 Back-to-back contiguous blocks SHALL stream with OUT_VALID continuously high (full throughput, no bubbles).
REQ-017 OUT_FIRST=OUT_VALID and RCNT=0; OUT_LAST=OUT_VALID and RCNT=LANES-1; with LANES beats both are never high together.
REQ-018 When OUT_VALID=0, Q SHALL hold its previous value.
REQ-019 BYPASS is sampled only when WCNT=0 and the sequencer is IDLE; a change at any other time is deferred until that condition holds.
REQ-020 Bypass mode behaviour:
  - Q<=D and OUT_VALID<=IN_VALID, one-cycle latency.
  - OUT_FIRST=OUT_LAST=OUT_VALID.
  - Banks are untouched.
REQ-021 No arithmetic; data is passed bit-exact with no width change.

Reset
REQ-022 RST=1 at a rising edge SHALL clear WCNT, RCNT, bank select, sequencer (IDLE), the mode latch (transpose), Q (all zero), OUT_VALID, OUT_FIRST and OUT_LAST.
REQ-023 Bank contents are not reset.
REQ-024 Reset mid-block or mid-READ SHALL discard all partial and pending blocks; the first valid beat after RST deassertion is beat 0 of a new block.
REQ-025 IN_VALID is ignored during any cycle with RST=1.

Configuration
REQ-026 Macro MDC_TRANSPOSE_BITREV_EN:
  - Defined: output beat r lane j = input beat bitrev(j) lane bitrev(r), where bitrev reverses log2(LANES) bits; OUT_FIRST/OUT_LAST still mark RCNT 0/LANES-1.
  - Undefined: natural order per REQ-011.
  - Bypass mode is unaffected either way.

Verification (LANES=4, DW=64; input beat b lane i = 64'h0000_00bi)
REQ-027 Contiguous single block b=0..3, macro undefined -> 4 output beats starting 5 cycles after first input; beat r lane j = 64'h0000_00jr; OUT_FIRST on beat 0, OUT_LAST on beat 3.
REQ-028 Three back-to-back blocks (12 contiguous beats) -> OUT_VALID high for 12 consecutive cycles; each block correctly transposed.
REQ-029 Block with IN_VALID gaps (pattern 1,0,1,0,0,1,1) -> output identical to REQ-027, starting 2 cycles after the last input beat.
REQ-030 RST pulsed after 2 beats, then a full block b=0..3 -> no output from the discarded beats; correct transposed block follows.
REQ-031 BYPASS=1 raised mid-block -> stays in transpose mode until the block has drained, then Q=D with 1-cycle latency and OUT_FIRST=OUT_LAST=1 per beat.
REQ-032 Macro defined, REQ-027 stimulus -> beat 1 lane 1 = 64'h0000_0022; beat 2 lane 0 = 64'h0000_0001.

Source files
------------

// File: rtl/mdc_transpose.sv
// ============================================================================
// Module   : mdc_transpose
// Purpose  : LANES x LANES corner-turn for multi-lane complex streams, with
//            ping-pong banks and a one-cycle pass-through (bypass) mode.
// Option   : define MDC_TRANSPOSE_BITREV_EN for bit-reversed read ordering.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdc_transpose #(
  parameter int LANES = 4,
  parameter int DW    = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                bypass,
  input  logic [LANES*DW-1:0] d,
  output logic                out_valid,
  output logic                out_first,
  output logic                out_last,
  output logic [LANES*DW-1:0] q
);

  localparam int              LW       = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0]   CNT_LAST = LW'(LANES - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_t;

  function automatic logic [LW-1:0] bitrev(input logic [LW-1:0] x);
    logic [LW-1:0] r;
    for (int k = 0; k < LW; k++) r[k] = x[LW-1-k];
    return r;
  endfunction

  state_t        state, state_nx;
  logic [LW-1:0] wcnt;
  logic [LW-1:0] rcnt, rcnt_nx;
  logic          wbank;
  logic          rbank, rbank_nx;
  logic          mode_byp;

  // [bank][input beat][input lane]
  logic [DW-1:0] mem [2][LANES][LANES];

  logic          byp_eff;
  logic          wr_en;
  logic          blk_done;
  logic [LANES*DW-1:0] rd_word;

  // Mode may only change on a block boundary with nothing left to drain;
  // otherwise the latched mode stays in force.
  assign byp_eff  = (wcnt == '0 && state == ST_IDLE) ? bypass : mode_byp;
  assign wr_en    = in_valid && !byp_eff;
  assign blk_done = wr_en && (wcnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt     <= '0;
      wbank    <= 1'b0;
      mode_byp <= 1'b0;
    end else begin
      mode_byp <= byp_eff;
      if (wr_en) wcnt <= wcnt + LW'(1);
      if (blk_done) wbank <= ~wbank;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int i = 0; i < LANES; i++) mem[wbank][wcnt][i] <= d[i*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      rcnt  <= '0;
      rbank <= 1'b0;
    end else begin
      state <= state_nx;
      rcnt  <= rcnt_nx;
      rbank <= rbank_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rcnt_nx  = rcnt;
    rbank_nx = rbank;
    case (state)
      ST_IDLE: begin
        if (blk_done) begin
          state_nx = ST_READ;
          rcnt_nx  = '0;
          rbank_nx = wbank;
        end
      end
      ST_READ: begin
        if (rcnt == CNT_LAST) begin
          rcnt_nx = '0;
          if (blk_done) rbank_nx = wbank;
          else          state_nx = ST_IDLE;
        end else begin
          rcnt_nx = rcnt + LW'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
        rcnt_nx  = '0;
      end
    endcase
  end

  for (genvar j = 0; j < LANES; j++) begin : g_rd_lane
`ifdef MDC_TRANSPOSE_BITREV_EN
    localparam logic [LW-1:0] ROW = bitrev(LW'(j));
    assign rd_word[j*DW +: DW] = mem[rbank][ROW][bitrev(rcnt)];
`else
    localparam logic [LW-1:0] ROW = LW'(j);
    assign rd_word[j*DW +: DW] = mem[rbank][ROW][rcnt];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else if (byp_eff) begin
      out_valid <= in_valid;
      out_first <= in_valid;
      out_last  <= in_valid;
      if (in_valid) q <= d;
    end else begin
      out_valid <= (state == ST_READ);
      out_first <= (state == ST_READ) && (rcnt == '0);
      out_last  <= (state == ST_READ) && (rcnt == CNT_LAST);
      if (state == ST_READ) q <= rd_word;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdc_transpose.sv
// ============================================================================
// Module   : tb_mdc_transpose
// Purpose  : Directed self-checking bench for mdc_transpose (LANES=4, DW=64).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdc_transpose;

  localparam int LANES = 4;
  localparam int DW    = 64;
  localparam int W     = LANES * DW;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         bypass;
  logic [W-1:0] d;
  logic         out_valid;
  logic         out_first;
  logic         out_last;
  logic [W-1:0] q;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int drv_cyc;

  logic [W-1:0] cap_q [$];
  logic [1:0]   cap_fl[$];
  int           cap_c [$];

  mdc_transpose #(.LANES(LANES), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .bypass   (bypass),
    .d        (d),
    .out_valid(out_valid),
    .out_first(out_first),
    .out_last (out_last),
    .q        (q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      cap_q.push_back(q);
      cap_fl.push_back({out_first, out_last});
      cap_c.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] brev2(input int x);
    logic [1:0] v;
    v = 2'(x);
    return {v[0], v[1]};
  endfunction

  // Input beat b lane i of block k = k*256 + b*16 + i
  function automatic logic [W-1:0] beat_in(input int b, input int k);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = 64'(k*256 + b*16 + i);
    return r;
  endfunction

  function automatic logic [W-1:0] exp_tr(input int r, input int k);
    logic [W-1:0] v;
    for (int j = 0; j < LANES; j++) begin
`ifdef MDC_TRANSPOSE_BITREV_EN
      v[j*DW +: DW] = 64'(k*256 + int'(brev2(j))*16 + int'(brev2(r)));
`else
      v[j*DW +: DW] = 64'(k*256 + j*16 + r);
`endif
    end
    return v;
  endfunction

  task automatic drive(input logic v, input logic byp, input logic [W-1:0] data);
    @(negedge clk);
    in_valid = v;
    bypass   = byp;
    d        = data;
    drv_cyc  = cyc;
  endtask

  task automatic idle(input int n, input logic byp);
    repeat (n) drive(1'b0, byp, '0);
  endtask

  task automatic clear_cap();
    cap_q.delete();
    cap_fl.delete();
    cap_c.delete();
  endtask

  task automatic check_block(input string tag, input int base, input int start, input int k);
    if (cap_q.size() < base + LANES) begin
      check({tag, "_count"}, W'(cap_q.size()), W'(base + LANES));
      return;
    end
    for (int r = 0; r < LANES; r++) begin
      check($sformatf("%s_q%0d", tag, r), cap_q[base+r], exp_tr(r, k));
      check($sformatf("%s_fl%0d", tag, r), W'(cap_fl[base+r]), W'({r == 0, r == LANES-1}));
      check($sformatf("%s_cyc%0d", tag, r), W'(cap_c[base+r]), W'(start + r));
    end
  endtask

  initial begin
    int s;
    int s_last;
    int c0, c1, c2;
    logic [W-1:0] x0, x1, x2;
    logic [W-1:0] pat;

    rst = 1'b1; in_valid = 1'b1; bypass = 1'b0; d = beat_in(3, 9);

    // Reset with IN_VALID asserted: nothing may be captured.
    repeat (3) @(negedge clk);
    check("rst_q", q, '0);
    check("rst_valid", W'(out_valid), W'(0));
    check("rst_flags", W'({out_first, out_last}), W'(0));
    rst = 1'b0; in_valid = 1'b0;
    idle(6, 1'b0);
    check("rst_no_output", W'(cap_q.size()), W'(0));

    // Single contiguous block
    clear_cap();
    drive(1'b1, 1'b0, beat_in(0, 0)); s = drv_cyc;
    for (int b = 1; b < LANES; b++) drive(1'b1, 1'b0, beat_in(b, 0));
    idle(8, 1'b0);
    check("single_count", W'(cap_q.size()), W'(LANES));
    check_block("single", 0, s + LANES + 1, 0);
    check("hold_q", q, exp_tr(LANES-1, 0));
    check("hold_valid", W'(out_valid), W'(0));

    // Three back-to-back blocks, distinct data per block
    clear_cap();
    drive(1'b1, 1'b0, beat_in(0, 1)); s = drv_cyc;
    for (int b = 1; b < 3*LANES; b++) drive(1'b1, 1'b0, beat_in(b % LANES, 1 + b / LANES));
    idle(10, 1'b0);
    check("b2b_count", W'(cap_q.size()), W'(3*LANES));
    for (int k = 0; k < 3; k++)
      check_block($sformatf("b2b%0d", k), k*LANES, s + LANES + 1 + k*LANES, 1 + k);

    // Block with IN_VALID gaps: 1,0,1,0,0,1,1
    clear_cap();
    pat = '0;
    pat[6:0] = 7'b1100101;
    begin
      int b;
      b = 0;
      for (int t = 0; t < 7; t++) begin
        if (pat[t]) begin
          drive(1'b1, 1'b0, beat_in(b, 0));
          b++;
          s_last = drv_cyc;
        end else begin
          drive(1'b0, 1'b0, beat_in(7, 7));
        end
      end
    end
    idle(8, 1'b0);
    check("gap_count", W'(cap_q.size()), W'(LANES));
    check_block("gap", 0, s_last + 2, 0);

    // Reset pulsed after two beats; a valid beat during reset must be ignored
    clear_cap();
    drive(1'b1, 1'b0, beat_in(0, 5));
    drive(1'b1, 1'b0, beat_in(1, 5));
    drive(1'b1, 1'b0, beat_in(2, 5));
    rst = 1'b1;
    drive(1'b1, 1'b0, beat_in(0, 6));
    rst = 1'b0;
    s = drv_cyc;
    for (int b = 1; b < LANES; b++) drive(1'b1, 1'b0, beat_in(b, 6));
    idle(8, 1'b0);
    check("rstmid_count", W'(cap_q.size()), W'(LANES));
    check_block("rstmid", 0, s + LANES + 1, 6);

    // BYPASS raised mid-block: block drains transposed, then pass-through
    clear_cap();
    drive(1'b1, 1'b0, beat_in(0, 7)); s = drv_cyc;
    drive(1'b1, 1'b0, beat_in(1, 7));
    drive(1'b1, 1'b1, beat_in(2, 7));
    drive(1'b1, 1'b1, beat_in(3, 7));
    idle(6, 1'b1);
    x0 = {4{64'hDEAD_BEEF_0000_0001}};
    x1 = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
          64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000};
    x2 = {4{64'h0123_4567_89AB_CDEF}};
    drive(1'b1, 1'b1, x0); c0 = drv_cyc;
    drive(1'b0, 1'b1, '0);
    drive(1'b1, 1'b1, x1); c1 = drv_cyc;
    drive(1'b1, 1'b1, x2); c2 = drv_cyc;
    idle(3, 1'b1);
    check("byp_count", W'(cap_q.size()), W'(LANES + 3));
    check_block("byp_drain", 0, s + LANES + 1, 7);
    if (cap_q.size() >= LANES + 3) begin
      check("byp_q0", cap_q[LANES],   x0);
      check("byp_q1", cap_q[LANES+1], x1);
      check("byp_q2", cap_q[LANES+2], x2);
      check("byp_fl0", W'(cap_fl[LANES]),   W'(2'b11));
      check("byp_fl2", W'(cap_fl[LANES+2]), W'(2'b11));
      check("byp_cyc0", W'(cap_c[LANES]),   W'(c0 + 1));
      check("byp_cyc1", W'(cap_c[LANES+1]), W'(c1 + 1));
      check("byp_cyc2", W'(cap_c[LANES+2]), W'(c2 + 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
